// File: rtl/nios2_pio_pkg.sv
// Shared constants and types for the Nios II input PIO with edge capture.
package nios2_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISING  = 2'd0,
    EDGE_FALLING = 2'd1,
    EDGE_ANY     = 2'd2
  } edge_type_t;

endpackage

// File: rtl/nios2_pio_in_sync_bit.sv
// One input bit: metastability synchroniser plus optional debouncer.
// Define NIOS2_PIO_IN_DEBOUNCE_EN to add the per-bit debounce counter.
module nios2_pio_in_sync_bit
  import nios2_pio_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic in_bit,
  output logic stable_bit
);

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   sync_val;

  always_ff @(posedge clk) begin
    if (reset) sync_chain <= '0;
    else       sync_chain <= {sync_chain[SYNC_STAGES-2:0], in_bit};
  end

  assign sync_val = sync_chain[SYNC_STAGES-1];

`ifdef NIOS2_PIO_IN_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] db_cnt;

  // Any return to agreement restarts the count, so short glitches never propagate.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_cnt     <= '0;
      stable_bit <= 1'b0;
    end else if (sync_val == stable_bit) begin
      db_cnt <= '0;
    end else if (db_cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
      stable_bit <= sync_val;
      db_cnt     <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

  assign stable_bit = sync_val;
`endif

endmodule

// File: rtl/nios2_pio_in_edge.sv
// Input-only Avalon-MM PIO with per-bit edge capture (W1C), IRQ mask and level IRQ.
// Define NIOS2_PIO_IN_DEBOUNCE_EN to debounce each input after synchronisation.
module nios2_pio_in_edge
  import nios2_pio_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int WARM_CYCLES = SYNC_STAGES + 1;
  localparam int WARM_W      = $clog2(WARM_CYCLES + 1);

  logic [WIDTH-1:0]  stable_val;
  logic [WIDTH-1:0]  prev_val;
  logic [WIDTH-1:0]  irq_mask;
  logic [WIDTH-1:0]  edge_capture;
  logic [WIDTH-1:0]  edge_raw;
  logic [WIDTH-1:0]  edge_det;
  logic [WIDTH-1:0]  w1c;
  logic [WARM_W-1:0] warm_cnt;
  logic              warm_done;
  logic              wr_en;
  logic              unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    nios2_pio_in_sync_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sync (
      .clk        (clk),
      .reset      (reset),
      .in_bit     (in_port[i]),
      .stable_bit (stable_val[i])
    );
  end

  assign wr_en        = chipselect && !write_n;
  assign unused_wdata = ^writedata;

  // Warm-up hides the sync chain filling after reset, so inputs already high don't capture.
  always_ff @(posedge clk) begin
    if (reset)           warm_cnt <= '0;
    else if (!warm_done) warm_cnt <= warm_cnt + 1'b1;
  end

  assign warm_done = (warm_cnt == WARM_W'(WARM_CYCLES));

  always_comb begin
    edge_raw = stable_val & ~prev_val;
    if (EDGE_TYPE == int'(EDGE_FALLING)) edge_raw = ~stable_val & prev_val;
    else if (EDGE_TYPE == int'(EDGE_ANY)) edge_raw = stable_val ^ prev_val;
    edge_det = warm_done ? edge_raw : '0;
    w1c      = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
  end

  // A new edge overrides a same-cycle clear of that bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_val     <= '0;
      irq_mask     <= '0;
      edge_capture <= '0;
    end else begin
      prev_val     <= stable_val;
      edge_capture <= (edge_capture & ~w1c) | edge_det;
      if (wr_en && address == ADDR_IRQMASK) irq_mask <= writedata[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      case (address)
        ADDR_DATA:    readdata <= 32'(stable_val);
        ADDR_IRQMASK: readdata <= 32'(irq_mask);
        ADDR_EDGECAP: readdata <= 32'(edge_capture);
        default:      readdata <= '0;
      endcase
    end
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_nios2_pio_in_edge.sv
// Directed bench: an 8-bit rising-edge PIO and a 32-bit any-edge PIO on a shared bus.
module tb_nios2_pio_in_edge;
  import nios2_pio_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic        cs_a, cs_b;
  logic [7:0]  in_a;
  logic [31:0] in_b;
  logic [31:0] rd_a, rd_b;
  logic        irq_a, irq_b;
  logic [31:0] rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nios2_pio_in_edge #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(16)) dut_a (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (cs_a),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_a),
    .readdata   (rd_a),
    .irq        (irq_a)
  );

  nios2_pio_in_edge #(.WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(16)) dut_b (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (cs_b),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_b),
    .readdata   (rd_b),
    .irq        (irq_b)
  );

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic write_reg(input bit to_b, input logic [1:0] addr, input logic [31:0] data);
    address   = addr;
    writedata = data;
    write_n   = 1'b0;
    cs_a      = !to_b;
    cs_b      = to_b;
    tick();
    cs_a    = 1'b0;
    cs_b    = 1'b0;
    write_n = 1'b1;
  endtask

  task automatic read_reg(input bit from_b, input logic [1:0] addr, output logic [31:0] data);
    address = addr;
    tick();
    data = from_b ? rd_b : rd_a;
  endtask

  initial begin
    reset     = 1'b1;
    address   = ADDR_DATA;
    write_n   = 1'b1;
    writedata = '0;
    cs_a      = 1'b0;
    cs_b      = 1'b0;
    in_a      = 8'hFF;
    in_b      = 32'hA5A5A5A5;
    tick(10);

    check_output("reset_rd_a", rd_a, 32'h0);
    check_output("reset_irq_a", 32'(irq_a), 32'h0);
    check_output("reset_rd_b", rd_b, 32'h0);

    reset = 1'b0;
    tick(10);

    read_reg(1'b0, ADDR_DATA, rd);
    check_output("a_data_ff", rd, 32'h000000FF);
    read_reg(1'b0, ADDR_EDGECAP, rd);
    check_output("a_warmup_cap", rd, 32'h0);
    check_output("a_warmup_irq", 32'(irq_a), 32'h0);

    read_reg(1'b1, ADDR_DATA, rd);
    check_output("b_data_a5", rd, 32'hA5A5A5A5);
    read_reg(1'b1, ADDR_RSVD, rd);
    check_output("b_rsvd", rd, 32'h0);
    read_reg(1'b1, ADDR_EDGECAP, rd);
    check_output("b_warmup_cap", rd, 32'h0);
    write_reg(1'b1, ADDR_DATA, 32'hFFFFFFFF);
    write_reg(1'b1, ADDR_RSVD, 32'hFFFFFFFF);
    read_reg(1'b1, ADDR_DATA, rd);
    check_output("b_data_ro", rd, 32'hA5A5A5A5);
    read_reg(1'b1, ADDR_RSVD, rd);
    check_output("b_rsvd_wr", rd, 32'h0);

    // Falling edges on a rising-edge port capture nothing
    in_a = 8'h00;
    tick(5);
    read_reg(1'b0, ADDR_EDGECAP, rd);
    check_output("a_fall_ignored", rd, 32'h0);
    read_reg(1'b0, ADDR_DATA, rd);
    check_output("a_data_00", rd, 32'h0);

    write_reg(1'b0, ADDR_IRQMASK, 32'h00000001);
    read_reg(1'b0, ADDR_IRQMASK, rd);
    check_output("a_mask_rb", rd, 32'h00000001);

    in_a = 8'h01;
    tick(2);
    check_output("a_irq_latency", 32'(irq_a), 32'h0);
    tick();
    check_output("a_irq_set", 32'(irq_a), 32'h1);
    read_reg(1'b0, ADDR_EDGECAP, rd);
    check_output("a_cap_bit0", rd, 32'h00000001);

    write_reg(1'b0, ADDR_EDGECAP, 32'h00000001);
    check_output("a_irq_cleared", 32'(irq_a), 32'h0);
    read_reg(1'b0, ADDR_EDGECAP, rd);
    check_output("a_cap_cleared", rd, 32'h0);

    // Bit 3: capture once, drop, then clear exactly when the next rising edge lands
    write_reg(1'b0, ADDR_IRQMASK, 32'h00000008);
    in_a = 8'h09;
    tick(4);
    check_output("a_irq_bit3", 32'(irq_a), 32'h1);
    in_a = 8'h01;
    tick(4);
    in_a = 8'h09;
    tick(2);
    write_reg(1'b0, ADDR_EDGECAP, 32'h00000008);
    check_output("a_set_wins_irq", 32'(irq_a), 32'h1);
    read_reg(1'b0, ADDR_EDGECAP, rd);
    check_output("a_set_wins_cap", rd, 32'h00000008);

    write_reg(1'b0, ADDR_EDGECAP, 32'h00000008);
    check_output("a_w1c_pre_update", rd_a, 32'h00000008);
    check_output("a_w1c_irq", 32'(irq_a), 32'h0);
    write_reg(1'b0, ADDR_EDGECAP, 32'h00000000);
    check_output("a_w1c_post", rd_a, 32'h0);

    // Any-edge port: falling edge on bit 5 captured while masked off
    in_b = 32'hA5A5A585;
    tick(4);
    read_reg(1'b1, ADDR_EDGECAP, rd);
    check_output("b_cap_fall5", rd, 32'h00000020);
    check_output("b_irq_masked", 32'(irq_b), 32'h0);
    write_reg(1'b1, ADDR_IRQMASK, 32'h00000020);
    check_output("b_irq_unmasked", 32'(irq_b), 32'h1);
    read_reg(1'b1, ADDR_IRQMASK, rd);
    check_output("b_mask_rb", rd, 32'h00000020);

    in_b = 32'hA5A5A587;
    tick(4);
    read_reg(1'b1, ADDR_EDGECAP, rd);
    check_output("b_cap_rise1", rd, 32'h00000022);
    write_reg(1'b1, ADDR_EDGECAP, 32'h00000002);
    read_reg(1'b1, ADDR_EDGECAP, rd);
    check_output("b_w1c_partial", rd, 32'h00000020);

    // Mid-operation reset drops pending captures and the mask
    reset = 1'b1;
    tick();
    check_output("b_reset_rd", rd_b, 32'h0);
    check_output("b_reset_irq", 32'(irq_b), 32'h0);
    reset = 1'b0;
    tick(10);
    read_reg(1'b1, ADDR_EDGECAP, rd);
    check_output("b_post_reset_cap", rd, 32'h0);
    read_reg(1'b1, ADDR_IRQMASK, rd);
    check_output("b_post_reset_mask", rd, 32'h0);
    read_reg(1'b1, ADDR_DATA, rd);
    check_output("b_post_reset_data", rd, 32'hA5A5A587);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
